// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready flow control, flush and a saturating stall counter.
// Define EX_MEM_PIPE_SKID_EN to add a one-entry skid buffer so in_ready no longer depends on out_ready.
module ex_mem_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int OP_W  = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  alu_result_in,
    input  logic [XLEN-1:0]  rs2_data_in,
    input  logic [RD_W-1:0]  rd_in,
    input  logic [OP_W-1:0]  opcode_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_result_out,
    output logic [XLEN-1:0]  rs2_data_out,
    output logic [RD_W-1:0]  rd_out,
    output logic [OP_W-1:0]  opcode_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int PW = 2*XLEN + RD_W + OP_W + 2;

    logic [PW-1:0] in_bus;
    logic [PW-1:0] main_q;
    logic          main_vld;
    logic          accept;

    assign in_bus = {alu_result_in, rs2_data_in, rd_in, opcode_in, mem_read_in, mem_write_in};
    assign accept = in_valid && in_ready;

`ifdef EX_MEM_PIPE_SKID_EN
    logic [PW-1:0] skid_q;
    logic          skid_vld;

    // skid_vld is a flop, so in_ready only sees flush combinationally
    assign in_ready = !flush && !skid_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld <= 1'b0;
            main_q   <= '0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            main_q   <= '0;
            skid_vld <= 1'b0;
        end else if (skid_vld) begin
            // skid only fills behind a full main entry, so draining refills main from skid
            if (out_ready) begin
                main_q   <= skid_q;
                skid_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!main_vld || out_ready) begin
                main_q   <= in_bus;
                main_vld <= 1'b1;
            end else begin
                skid_q   <= in_bus;
                skid_vld <= 1'b1;
            end
        end else if (main_vld && out_ready) begin
            main_vld <= 1'b0;
        end
    end
`else
    assign in_ready = !flush && (!main_vld || out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld <= 1'b0;
            main_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            main_q   <= '0;
        end else if (accept) begin
            main_q   <= in_bus;
            main_vld <= 1'b1;
        end else if (main_vld && out_ready) begin
            main_vld <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (main_vld && !out_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end

    assign out_valid = main_vld;
    assign {alu_result_out, rs2_data_out, rd_out, opcode_out, mem_read_out, mem_write_out} = main_q;

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX→MEM pipeline register with valid/ready flow control, flush and a stall-cycle counter. It sits between the execute stage and the memory stage. Each transfer carries the ALU result, store data (rs2), destination register index, opcode and memory read/write strobes. Unlike a free-running stage latch, it can hold data under back-pressure without loss and can optionally absorb one extra beat in a skid entry so `in_ready` is a registered signal.

## Interface
- `XLEN`, 32: width of `alu_result` and `rs2_data`.
- `RD_W`, 5: width of the destination register index.
- `OP_W`, 6: width of the opcode field.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous kill of all held entries.
- `in_valid` in 1: EX presents a beat.
- `in_ready` out 1: stage can accept a beat.
- `alu_result_in` in XLEN; `rs2_data_in` in XLEN; `rd_in` in RD_W; `opcode_in` in OP_W; `mem_read_in` in 1; `mem_write_in` in 1: payload.
- `out_valid` out 1: MEM-side beat valid.
- `out_ready` in 1: MEM accepts the beat.
- `alu_result_out`, `rs2_data_out`, `rd_out`, `opcode_out`, `mem_read_out`, `mem_write_out` out (matching widths): registered payload.
- `stall_cycles` out CNT_W: saturating count of back-pressured cycles.

## Operation
- Handshakes:
  - A transfer occurs on an edge where valid && ready, on either side.
  - Payload in = {alu_result, rs2_data, rd, opcode, mem_read, mem_write}.
- Main register:
  - Loads on an input transfer when it is empty or draining (out_valid && out_ready).
  - Otherwise holds; output payload stays stable while out_valid && !out_ready.
  - When empty, the payload retains its last value; it is not zeroed.
- Flush:
  - Next edge: out_valid=0, skid emptied, all payload outputs = 0.
  - While flush=1, in_ready=0, so no beat is accepted in that cycle. The flush takes priority over a simultaneous out_ready.
- Stall counter:
  - Increments on each edge where out_valid && !out_ready.
  - Saturates at 2^CNT_W−1; never wraps.
  - Cleared only by reset; flush does not clear it.
- Reset values:
  - out_valid=0, in_ready=1, every payload output 0, stall_cycles=0, skid empty.
  - If reset asserts mid-transfer, the beat is lost. No output glitches to a nonzero payload.

## Timing
- Latency: a beat accepted on edge N appears with out_valid=1 after edge N (one cycle). This holds when the stage was empty or drained on edge N.
- Throughput: one beat per cycle when out_ready is held at 1.
- Simultaneous accept and drain on the same edge: the new beat replaces the old one. out_valid stays 1 with no bubble.
- Without skid, `in_ready` = !flush && (!out_valid || out_ready), which is combinational from `out_ready`.

## Configuration
- Macro: `EX_MEM_PIPE_SKID_EN`.
- Defined:
  - Adds a one-entry skid register, and `in_ready` becomes registered: in_ready = !flush && skid_empty.
  - If a beat is accepted while out_valid && !out_ready, the beat goes to the skid.
  - On the next drain, the skid moves to main and in_ready rises on the following edge.
  - Capacity is 2 beats. Ordering is strictly FIFO.
- Undefined:
  - Single entry, capacity 1.
  - `in_ready` is the combinational expression given under Timing.
  - No skid storage is synthesised.

## Test plan
- Reset, then stream 4 beats (alu_result 0x10..0x13, rd 1..4) with out_ready=1 -> outputs appear 1 cycle after each accept, in order, with no bubbles, and stall_cycles=0.
- Accept beat A=0xAAAA_0001, then hold out_ready=0 for 5 cycles -> alu_result_out stays 0xAAAA_0001 and stall_cycles=5. In skid mode a second beat B is accepted and in_ready drops. Release out_ready -> A then B.
- Assert flush with both entries full -> next cycle out_valid=0, all payload outputs 0, and in_ready=0 during the flush cycle. stall_cycles is unchanged.
- Hold out_ready=0 with CNT_W=4 for 20 cycles -> stall_cycles saturates at 15.
- Assert reset asynchronously mid-cycle while out_valid=1 and rs2_data_out=0x1234 -> outputs go to 0 before the next clock edge. in_ready=1 after release.
- Random valid/ready for 10k cycles, checked against a reference queue model -> no loss, duplication or reordering, and the payload is stable while stalled.
